// File: rtl/lot_pkg.sv
// lot_pkg: shared gate FSM state type and seven-segment codes for the parking-lot counter
package lot_pkg;

    typedef enum logic [2:0] {
        G_IDLE,
        G_IN1,
        G_IN12,
        G_IN2,
        G_OUT2,
        G_OUT21,
        G_OUT1,
        G_ERR
    } gate_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    return SEG_0;
            7'd1:    return SEG_1;
            7'd2:    return SEG_2;
            7'd3:    return SEG_3;
            7'd4:    return SEG_4;
            7'd5:    return SEG_5;
            7'd6:    return SEG_6;
            7'd7:    return SEG_7;
            7'd8:    return SEG_8;
            7'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/lot_gate_fsm.sv
// lot_gate_fsm: debounces one sensor pair and decodes entry/exit/abort sequences for one gate
module lot_gate_fsm
    import lot_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic sens1_i,
    input  logic sens2_i,
    output logic inc_o,
    output logic dec_o,
    output logic err_o
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    logic [1:0]    sync1_q, sync2_q, filt_q, filt_d;
    logic [DW-1:0] db_q [2];
    logic [DW-1:0] db_d [2];
    gate_state_t   state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          inc_q, inc_d, dec_q, dec_d, err_q, err_d;

    // a filtered bit flips only after DEBOUNCE consecutive samples disagree with it
    always_comb begin
        filt_d = filt_q;
        db_d   = db_q;
        for (int i = 0; i < 2; i++) begin
            db_d[i]   = (sync2_q[i] == filt_q[i] || db_q[i] == DB_MAX) ? '0 : db_q[i] + 1'b1;
            filt_d[i] = (sync2_q[i] != filt_q[i] && db_q[i] == DB_MAX) ? sync2_q[i] : filt_q[i];
        end
    end

    // sequence decode on {s1,s2}; backing out is legal, anything else aborts
    always_comb begin
        state_d = state_q;
        case (state_q)
            G_IDLE:  state_d = filt_q == 2'b10 ? G_IN1  : filt_q == 2'b01 ? G_OUT2  : filt_q == 2'b11 ? G_ERR  : G_IDLE;
            G_IN1:   state_d = filt_q == 2'b10 ? G_IN1  : filt_q == 2'b11 ? G_IN12  : filt_q == 2'b00 ? G_IDLE : G_ERR;
            G_IN12:  state_d = filt_q == 2'b11 ? G_IN12 : filt_q == 2'b01 ? G_IN2   : filt_q == 2'b10 ? G_IN1  : G_ERR;
            G_IN2:   state_d = filt_q == 2'b01 ? G_IN2  : filt_q == 2'b00 ? G_IDLE  : filt_q == 2'b11 ? G_IN12 : G_ERR;
            G_OUT2:  state_d = filt_q == 2'b01 ? G_OUT2 : filt_q == 2'b11 ? G_OUT21 : filt_q == 2'b00 ? G_IDLE : G_ERR;
            G_OUT21: state_d = filt_q == 2'b11 ? G_OUT21 : filt_q == 2'b10 ? G_OUT1 : filt_q == 2'b01 ? G_OUT2 : G_ERR;
            G_OUT1:  state_d = filt_q == 2'b10 ? G_OUT1 : filt_q == 2'b00 ? G_IDLE  : filt_q == 2'b11 ? G_OUT21 : G_ERR;
            G_ERR:   state_d = filt_q == 2'b00 ? G_IDLE : G_ERR;
            default: state_d = G_IDLE;
        endcase
        if (state_d == state_q && state_q != G_IDLE && state_q != G_ERR && tmo_q == TMO_MAX)
            state_d = G_ERR;
        tmo_d = (state_d != state_q || state_q == G_IDLE || state_q == G_ERR) ? '0 : tmo_q + 1'b1;
        inc_d = state_q == G_IN2 && state_d == G_IDLE;
        dec_d = state_q == G_OUT1 && state_d == G_IDLE;
        err_d = state_q != G_ERR && state_d == G_ERR;
    end

    // synchroniser, debouncer, FSM and one-clock event registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            db_q    <= '{default: '0};
            state_q <= G_IDLE;
            tmo_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {sens1_i, sens2_i};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            db_q    <= db_d;
            state_q <= state_d;
            tmo_q   <= tmo_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
        end
    end

    assign inc_o = inc_q;
    assign dec_o = dec_q;
    assign err_o = err_q;

endmodule

// File: rtl/lot_counter_multi.sv
// lot_counter_multi: multi-gate parking-lot occupancy counter with saturation, error status and 7-segment display
module lot_counter_multi
    import lot_pkg::*;
#(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 99,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_GATES-1:0] sens1,
    input  logic [N_GATES-1:0] sens2,
    input  logic               clr_err,
    output logic [6:0]         count,
    output logic               full,
    output logic [N_GATES-1:0] err_pulse,
    output logic [N_GATES-1:0] err_sticky,
    output logic [6:0]         ones,
    output logic [6:0]         tens
);

    localparam logic signed [9:0] CAP_S = 10'(CAPACITY);

    logic [N_GATES-1:0] inc, dec, err;
    logic [N_GATES-1:0] err_sticky_q;
    logic [3:0]         n_inc, n_dec;
    logic signed [9:0]  sum;
    logic [6:0]         count_q, count_d, ones_q, tens_q, ones_dig, tens_dig;
    logic               full_q;

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        lot_gate_fsm #(
            .DEBOUNCE(DEBOUNCE),
            .TIMEOUT (TIMEOUT)
        ) u_gate (
            .clk    (clk),
            .rst    (rst),
            .sens1_i(sens1[g]),
            .sens2_i(sens2[g]),
            .inc_o  (inc[g]),
            .dec_o  (dec[g]),
            .err_o  (err[g])
        );
    end

    // net all gate events into one signed delta and clamp silently to [0, CAPACITY]
    always_comb begin
        n_inc = '0;
        n_dec = '0;
        for (int i = 0; i < N_GATES; i++) begin
            n_inc = n_inc + 4'(inc[i]);
            n_dec = n_dec + 4'(dec[i]);
        end
        sum      = 10'(count_q) + 10'(n_inc) - 10'(n_dec);
        count_d  = sum < 0 ? '0 : sum > CAP_S ? 7'(CAPACITY) : sum[6:0];
        ones_dig = count_q % 7'd10;
        tens_dig = count_q / 7'd10;
    end

    // occupancy, full flag, sticky errors and display digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            full_q       <= 1'b0;
            err_sticky_q <= '0;
            ones_q       <= SEG_0;
            tens_q       <= SEG_BLANK;
        end else begin
            count_q      <= count_d;
            full_q       <= count_d == 7'(CAPACITY);
            err_sticky_q <= err | (clr_err ? '0 : err_sticky_q);
            ones_q       <= seg7(ones_dig);
            tens_q       <= tens_dig == '0 ? SEG_BLANK : seg7(tens_dig);
        end
    end

    assign count      = count_q;
    assign full       = full_q;
    assign err_pulse  = err;
    assign err_sticky = err_sticky_q;
    assign ones       = ones_q;
    assign tens       = tens_q;

endmodule

// File: tb/tb_lot_counter_multi.sv
// tb_lot_counter_multi: scoreboard bench for the multi-gate lot counter (full-size and CAPACITY=5 instances)
module tb_lot_counter_multi;

    localparam int HOLD = 40;
    localparam int TMO  = 200;
    localparam logic [6:0] S0 = 7'h3F;
    localparam logic [6:0] S1 = 7'h06;
    localparam logic [6:0] S9 = 7'h6F;
    localparam logic [6:0] SB = 7'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_err = 1'b0;
    logic [1:0] s1_a = '0, s2_a = '0, s1_b = '0, s2_b = '0;
    logic [6:0] count_a, count_b, ones_a, ones_b, tens_a, tens_b;
    logic       full_a, full_b;
    logic [1:0] errp_a, errp_b, errs_a, errs_b;

    int n_chk = 0;
    int n_err = 0;
    int qa[$];
    int qb[$];
    int exp_cnt[2] = '{0, 0};
    int cap[2] = '{99, 5};
    int err_n_a[2] = '{0, 0};
    int err_n_b[2] = '{0, 0};

    always #5 clk = ~clk;

    lot_counter_multi #(.N_GATES(2), .CAPACITY(99), .DEBOUNCE(4), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst(rst), .sens1(s1_a), .sens2(s2_a), .clr_err(clr_err),
        .count(count_a), .full(full_a), .err_pulse(errp_a), .err_sticky(errs_a),
        .ones(ones_a), .tens(tens_a)
    );

    lot_counter_multi #(.N_GATES(2), .CAPACITY(5), .DEBOUNCE(4), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst(rst), .sens1(s1_b), .sens2(s2_b), .clr_err(clr_err),
        .count(count_b), .full(full_b), .err_pulse(errp_b), .err_sticky(errs_b),
        .ones(ones_b), .tens(tens_b)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_gate(input int d, input int g, input logic a, input logic b);
        if (d == 0) begin
            s1_a[g] = a;
            s2_a[g] = b;
        end else begin
            s1_b[g] = a;
            s2_b[g] = b;
        end
    endtask

    // full entry (s1, both, s2, none) or exit (mirror); expected count is queued up front
    task automatic run_seq(input int d, input int g, input logic entry);
        int nxt;
        nxt = entry ? (exp_cnt[d] < cap[d] ? exp_cnt[d] + 1 : exp_cnt[d])
                    : (exp_cnt[d] > 0 ? exp_cnt[d] - 1 : 0);
        if (nxt != exp_cnt[d]) begin
            if (d == 0) qa.push_back(nxt);
            else qb.push_back(nxt);
        end
        exp_cnt[d] = nxt;
        set_gate(d, g, entry, !entry);
        hold(HOLD);
        set_gate(d, g, 1'b1, 1'b1);
        hold(HOLD);
        set_gate(d, g, !entry, entry);
        hold(HOLD);
        set_gate(d, g, 1'b0, 1'b0);
        hold(HOLD);
    endtask

    // every count change is matched against the next queued expectation
    initial begin
        logic [6:0] prev_a, prev_b;
        prev_a = '0;
        prev_b = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (errp_a[g]) err_n_a[g]++;
                if (errp_b[g]) err_n_b[g]++;
            end
            if (!rst && count_a != prev_a) begin
                if (qa.size() == 0) check("sb_a_spurious", int'(count_a), int'(prev_a));
                else check("sb_a", int'(count_a), qa.pop_front());
            end
            if (!rst && count_b != prev_b) begin
                if (qb.size() == 0) check("sb_b_spurious", int'(count_b), int'(prev_b));
                else check("sb_b", int'(count_b), qb.pop_front());
            end
            prev_a = count_a;
            prev_b = count_b;
        end
    end

    initial begin
        hold(3);
        check("rst_count", int'(count_a), 0);
        check("rst_full", int'(full_a), 0);
        check("rst_ones", int'(ones_a), int'(S0));
        check("rst_tens", int'(tens_a), int'(SB));
        check("rst_errs", int'(errs_a), 0);
        check("rst_errp", int'(errp_a), 0);
        rst = 1'b0;
        hold(5);

        set_gate(0, 0, 1'b1, 1'b0);
        hold(HOLD);
        set_gate(0, 0, 1'b1, 1'b1);
        hold(HOLD);
        rst = 1'b1;
        set_gate(0, 0, 1'b0, 1'b1);
        hold(3);
        check("midrst_count", int'(count_a), 0);
        check("midrst_ones", int'(ones_a), int'(S0));
        check("midrst_tens", int'(tens_a), int'(SB));
        rst = 1'b0;
        hold(HOLD);
        set_gate(0, 0, 1'b0, 1'b0);
        hold(HOLD);
        check("midrst_noinc", int'(count_a), 0);
        check("midrst_noerr", int'(errs_a), 0);

        run_seq(0, 0, 1'b1);
        check("single_count", int'(count_a), 1);
        check("single_noerr", err_n_a[0], 0);

        for (int i = 0; i < 11; i++) run_seq(0, 0, 1'b1);
        check("twelve_in", int'(count_a), 12);
        for (int i = 0; i < 3; i++) run_seq(0, 1, 1'b0);
        check("nine_count", int'(count_a), 9);
        check("nine_ones", int'(ones_a), int'(S9));
        check("nine_tens", int'(tens_a), int'(SB));
        run_seq(0, 0, 1'b1);
        check("ten_count", int'(count_a), 10);
        check("ten_ones", int'(ones_a), int'(S0));
        check("ten_tens", int'(tens_a), int'(S1));
        check("ten_full", int'(full_a), 0);

        set_gate(0, 0, 1'b1, 1'b0);
        set_gate(0, 1, 1'b0, 1'b1);
        hold(HOLD);
        set_gate(0, 0, 1'b1, 1'b1);
        set_gate(0, 1, 1'b1, 1'b1);
        hold(HOLD);
        set_gate(0, 0, 1'b0, 1'b1);
        set_gate(0, 1, 1'b1, 1'b0);
        hold(HOLD);
        set_gate(0, 0, 1'b0, 1'b0);
        set_gate(0, 1, 1'b0, 1'b0);
        hold(HOLD);
        check("simul_count", int'(count_a), 10);

        set_gate(0, 1, 1'b1, 1'b1);
        hold(HOLD);
        check("both_rise_pulse", err_n_a[1], 1);
        check("both_rise_sticky", int'(errs_a[1]), 1);
        check("both_rise_count", int'(count_a), 10);
        set_gate(0, 1, 1'b0, 1'b0);
        hold(HOLD);
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        hold(2);
        check("clr_sticky", int'(errs_a), 0);

        set_gate(0, 0, 1'b1, 1'b1);
        hold(2);
        set_gate(0, 0, 1'b0, 1'b0);
        hold(HOLD);
        check("glitch_noerr", err_n_a[0], 0);
        check("glitch_sticky", int'(errs_a), 0);

        set_gate(0, 0, 1'b1, 1'b0);
        hold(TMO - 20);
        check("tmo_early", err_n_a[0], 0);
        hold(30);
        check("tmo_fired", err_n_a[0], 1);
        check("tmo_sticky", int'(errs_a), 1);
        set_gate(0, 0, 1'b0, 1'b0);
        hold(HOLD);
        check("tmo_count", int'(count_a), 10);
        run_seq(0, 0, 1'b1);
        check("after_err_entry", int'(count_a), 11);

        run_seq(1, 0, 1'b0);
        check("b_exit_at_zero", int'(count_b), 0);
        for (int i = 0; i < 7; i++) run_seq(1, 0, 1'b1);
        check("b_sat_count", int'(count_b), 5);
        check("b_sat_full", int'(full_b), 1);
        check("b_sat_ones", int'(ones_b), 7'h6D);
        run_seq(1, 1, 1'b0);
        check("b_unsat_count", int'(count_b), 4);
        check("b_unsat_full", int'(full_b), 0);
        check("b_noerr0", err_n_b[0], 0);
        check("b_noerr1", err_n_b[1], 0);
        check("b_tens", int'(tens_b), int'(SB));

        hold(5);
        check("sb_a_drain", qa.size(), 0);
        check("sb_b_drain", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lot_counter_multi.md
Name: lot_counter_multi

Overview:
- Parametrised successor to the single-entrance parking-lot counter.
- Tracks lot occupancy across N_GATES independent gates. Each gate has an outer/inner sensor pair, and its direction is decoded by a per-gate sequence FSM.
- Occupancy saturates at CAPACITY. Outputs are a FULL flag, an error pulse per gate, and two 7-segment digits (ones, tens) for a display-board top level.

Parameters:
- N_GATES, 2, number of independent gates (1..8)
- CAPACITY, 99, maximum occupancy (1..99, display limit)
- DEBOUNCE, 4, clocks a sensor level must hold before it is accepted (>=1)
- TIMEOUT, 200, clocks a gate FSM may stay in a non-idle state before aborting with an error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sens1  in  N_GATES  outer sensor per gate (1 = beam broken)
- sens2  in  N_GATES  inner sensor per gate
- clr_err  in  1  synchronous clear of the sticky error status
- count  out  7  current occupancy, binary
- full  out  1  high while count == CAPACITY
- err_pulse  out  N_GATES  one-clock pulse when a gate aborts a sequence
- err_sticky  out  N_GATES  latched OR of err_pulse, cleared by clr_err
- ones  out  7  7-segment code of count%10, active-high segments {g..a}
- tens  out  7  7-segment code of count/10; blank (7'h00) when tens digit is 0

Behaviour:
- Reset, asynchronous: count=0, full=0, err_pulse=0, err_sticky=0, all gate FSMs IDLE, debouncers cleared to 0, ones=segment '0', tens=blank.
- Debounce, per sensor bit:
  - 2-flop synchroniser, then a counter.
  - The filtered level changes only after DEBOUNCE consecutive equal samples.
  - Sensor-to-filtered latency is 2+DEBOUNCE clocks.
- Gate FSM, per gate, on filtered {s1,s2}:
  - States: IDLE, IN1 (s1 only), IN12 (both), IN2 (s2 only), OUT2, OUT21, OUT1.
  - Entry sequence: s1 -> s1&s2 -> s2 -> none. On the final return to none, emit inc for one clock.
  - Exit sequence: the mirror, s2 -> both -> s1 -> none. On the final return to none, emit dec.
  - Backing out (reverse step toward IDLE) is legal and produces no event, e.g. IN12 -> IN1 -> IDLE.
  - Both sensors rising together from IDLE is illegal: go to ERR and emit err_pulse.
  - Any other illegal transition also goes to ERR and emits err_pulse.
  - The TIMEOUT counter expiring in any non-IDLE state goes to ERR and emits err_pulse.
  - ERR waits until both filtered sensors are 0, then returns to IDLE. No event is emitted.
- Occupancy update, once per clock:
  - delta = (number of inc) - (number of dec) across all gates in the same clock.
  - new = count + delta, clamped to the range [0, CAPACITY].
  - Clamping is silent: no error is raised.
  - Simultaneous inc and dec therefore net out.
- full is registered and valid the same clock as count.
- ones and tens are registered from count, one clock after count updates.
- err_sticky[i] sets on err_pulse[i]. clr_err clears it; if a set and clr_err occur in the same clock, set wins.
- rst asserted mid-sequence aborts all FSMs immediately. No event is emitted.

Decomposition:
- Package lot_pkg holds:
  - gate_state_t enum
  - the seven-segment lookup constants SEG_0..SEG_9 and SEG_BLANK
- Sub-module lot_gate_fsm holds one debouncer pair, the FSM and the timeout counter. It is instantiated N_GATES times via generate.

Test Plan:
- Reset check, mid-sequence: start entry on gate 0, assert rst at its IN12 state -> count=0, ones=SEG_0, tens=SEG_BLANK, and no inc after release.
- Single entry: gate 0 runs s1, both, s2, none, each held 40 clocks -> count 0->1 exactly once, err_pulse=0.
- Entry and exit: 12 entries on gate 0, then 3 exits on gate 1 -> count=9, ones=SEG_9, tens blank. Then 1 more entry -> count=10, tens=SEG_1, ones=SEG_0.
- Simultaneous events: gate 0 completes an entry and gate 1 completes an exit in the same clock -> count unchanged.
- Saturation: with CAPACITY=5, drive 7 entries -> count=5, full=1. Then 1 exit -> count=4, full=0. Separately, an exit at count=0 -> count stays 0.
- Errors:
  - sens1 and sens2 rise on the same clock on gate 1 -> err_pulse[1] for 1 clock, err_sticky[1]=1, count unchanged. Then clr_err -> err_sticky=0.
  - Hold s1 only for TIMEOUT+1 clocks -> err_pulse fires.
  - A 2-clock glitch with DEBOUNCE=4 -> no state change.
